// File: rtl/alu_step_sequencer_pkg.sv
// alu_step_sequencer_pkg: shared FSM states, IR field positions and multi-word opcodes
package alu_step_sequencer_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;
  localparam int OPC_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
endpackage

// File: rtl/alu_step_regdec.sv
// alu_step_regdec: 4-bit register index to one-hot select with out-of-range flag
module alu_step_regdec #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel,
  output logic                oor
);
  assign oor = {1'b0, idx} >= 5'(NUM_REGS);
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_sel
    assign sel[i] = en && idx == 4'(i);
  end
endmodule

// File: rtl/alu_step_sequencer.sv
// alu_step_sequencer: Moore control-step sequencer for one register-register ALU instruction
module alu_step_sequencer
  import alu_step_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPCODE_W = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                err
);
  state_t state, state_nx;
  logic err_q, ir_unused;
  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic [NUM_REGS-1:0] rb_sel, rc_sel;
  logic ra_oor, rb_oor, rc_oor, range_err, is_muldiv;
  assign opc = ir[OPC_LSB +: 5];
  assign ra = ir[RA_LSB +: 4];
  assign rb = ir[RB_LSB +: 4];
  assign rc = ir[RC_LSB +: 4];
  assign ir_unused = ^ir[RC_LSB-1:0];
  assign is_muldiv = opc == OP_MUL || opc == OP_DIV;
  assign range_err = ra_oor || rb_oor || rc_oor;
  alu_step_regdec #(.NUM_REGS(NUM_REGS)) u_ra (.idx(ra), .en(state == S_T5 && !is_muldiv), .sel(reg_in), .oor(ra_oor));
  alu_step_regdec #(.NUM_REGS(NUM_REGS)) u_rb (.idx(rb), .en(state == S_T3), .sel(rb_sel), .oor(rb_oor));
  alu_step_regdec #(.NUM_REGS(NUM_REGS)) u_rc (.idx(rc), .en(state == S_T4), .sel(rc_sel), .oor(rc_oor));
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_T3) err_q <= range_err;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      state_nx = start ? S_T0 : S_IDLE;
      S_T0:        state_nx = S_T1;
      S_T1, S_T1W: state_nx = mem_ready ? S_T2 : S_T1W;
      S_T2:        state_nx = S_T3;
      S_T3:        state_nx = range_err ? S_DONE : S_T4;
      S_T4:        state_nx = S_T5;
      S_T5:        state_nx = is_muldiv ? S_T6 : S_DONE;
      S_T6:        state_nx = S_DONE;
      default:     state_nx = S_IDLE;
    endcase
  end
  // a bad index suppresses every T3 strobe so nothing reaches the bus
  assign reg_out = (range_err ? '0 : rb_sel) | rc_sel;
  assign Yin = state == S_T3 && !range_err;
  assign PCout = state == S_T0;
  assign MARin = state == S_T0;
  assign IncPC = state == S_T0;
  assign Zin = state == S_T0 || state == S_T4;
  assign Zlowout = state == S_T1 || state == S_T5;
  assign PCin = state == S_T1;
  assign Read = state == S_T1 || state == S_T1W;
  assign MDRin = state == S_T1 || state == S_T1W;
  assign MDRout = state == S_T2;
  assign IRin = state == S_T2;
  assign LOin = state == S_T5 && is_muldiv;
  assign Zhighout = state == S_T6;
  assign HIin = state == S_T6;
  assign alu_op = state == S_T4 ? OPCODE_W'(opc) : '0;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign err = state == S_DONE && err_q;
endmodule

// File: tb/tb_alu_step_sequencer.sv
// tb_alu_step_sequencer: directed checks of the step sequencer with 16 and 4 registers
module tb_alu_step_sequencer;
  logic clock = 1'b0, clear = 1'b0, start = 1'b0, mem_ready = 1'b1;
  logic [31:0] ir = '0;
  logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] reg_out, reg_in;
  logic [4:0] alu_op;
  logic busy, done, err;
  logic b_PCout, b_MARin, b_IncPC, b_Zin, b_Zlowout, b_Zhighout, b_PCin, b_Read, b_MDRin, b_MDRout, b_IRin, b_Yin, b_HIin, b_LOin;
  logic [3:0] b_reg_out, b_reg_in;
  logic [4:0] b_alu_op;
  logic b_busy, b_done, b_err;
  logic [13:0] strb, b_strb;
  int compared = 0, mismatched = 0, pcin_cnt = 0;
  alu_step_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .HIin(HIin),
    .LOin(LOin), .reg_out(reg_out), .reg_in(reg_in), .alu_op(alu_op), .busy(busy), .done(done), .err(err)
  );
  alu_step_sequencer #(.NUM_REGS(4)) dut_b (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(b_PCout), .MARin(b_MARin), .IncPC(b_IncPC), .Zin(b_Zin), .Zlowout(b_Zlowout), .Zhighout(b_Zhighout),
    .PCin(b_PCin), .Read(b_Read), .MDRin(b_MDRin), .MDRout(b_MDRout), .IRin(b_IRin), .Yin(b_Yin), .HIin(b_HIin),
    .LOin(b_LOin), .reg_out(b_reg_out), .reg_in(b_reg_in), .alu_op(b_alu_op), .busy(b_busy), .done(b_done), .err(b_err)
  );
  assign strb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin};
  assign b_strb = {b_PCout, b_MARin, b_IncPC, b_Zin, b_Zlowout, b_Zhighout, b_PCin, b_Read, b_MDRin, b_MDRout, b_IRin, b_Yin, b_HIin, b_LOin};
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [13:0] e_s, input logic [15:0] e_ro, input logic [15:0] e_ri,
                     input logic [4:0] e_op, input logic e_busy, input logic e_done, input logic e_err);
    chk({tag, " strobes"}, strb, e_s);
    chk({tag, " reg_out"}, reg_out, e_ro);
    chk({tag, " reg_in"}, reg_in, e_ri);
    chk({tag, " alu_op"}, alu_op, e_op);
    chk({tag, " busy"}, busy, e_busy);
    chk({tag, " done"}, done, e_done);
    chk({tag, " err"}, err, e_err);
  endtask
  task automatic cyc_b(input string tag, input logic [13:0] e_s, input logic [3:0] e_ro,
                       input logic e_busy, input logic e_done, input logic e_err);
    chk({tag, " strobes"}, b_strb, e_s);
    chk({tag, " reg_out"}, b_reg_out, e_ro);
    chk({tag, " reg_in"}, b_reg_in, 4'h0);
    chk({tag, " busy"}, b_busy, e_busy);
    chk({tag, " done"}, b_done, e_done);
    chk({tag, " err"}, b_err, e_err);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic add_run(input string tag);
    cyc({tag, "_t0"}, 14'h3C00, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc({tag, "_t1"}, 14'h02E0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc({tag, "_t2"}, 14'h0018, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc({tag, "_t3"}, 14'h0004, 16'h0020, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc({tag, "_t4"}, 14'h0400, 16'h0080, 16'h0, 5'h05, 1'b1, 1'b0, 1'b0);
    tick(); cyc({tag, "_t5"}, 14'h0200, 16'h0, 16'h0010, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc({tag, "_done"}, 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b1, 1'b0);
    tick(); cyc({tag, "_idle"}, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic run_latency(input string tag, input logic [31:0] w, input int exp);
    int n;
    ir = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, exp);
    tick();
  endtask
  // bus exclusivity must hold in every cycle of every run
  always @(negedge clock) begin
    if (PCin) pcin_cnt++;
    chk("bus_exclusive", ($countones(reg_out) <= 1) && ($countones(reg_in) <= 1) &&
        !(|reg_out && (MDRout || Zlowout || Zhighout || PCout)), 1'b1);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end
  initial begin
    #3;
    cyc("reset", 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);
    cyc_b("reset_b", 14'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    clear = 1'b1;
    tick();
    tick();
    ir = 32'h2A2B8000;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc_b("oor_t0", 14'h3C00, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc("add_t0", 14'h3C00, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc_b("oor_t1", 14'h02E0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc_b("oor_t2", 14'h0018, 4'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc_b("oor_t3", 14'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc_b("oor_done", 14'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    chk("add_t4 alu_op", alu_op, 5'h05);
    tick(); cyc_b("oor_idle", 14'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("add_t5 reg_in", reg_in, 16'h0010);
    tick(); chk("add_done", done, 1'b1);
    chk("add_done err", err, 1'b0);
    tick();
    ir = 32'h78130000;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc("mul_t0", 14'h3C00, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc("mul_t1", 14'h02E0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc("mul_t2", 14'h0018, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc("mul_t3", 14'h0004, 16'h0004, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc("mul_t4", 14'h0400, 16'h0040, 16'h0, 5'h0F, 1'b1, 1'b0, 1'b0);
    tick(); cyc("mul_t5", 14'h0201, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc("mul_t6", 14'h0102, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc("mul_done", 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b1, 1'b0);
    tick(); cyc("mul_idle", 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);
    run_latency("div_latency", 32'h80918000, 8);
    run_latency("sub_latency", 32'h10918000, 7);
    ir = 32'h2A2B8000;
    pcin_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc("wait_t0", 14'h3C00, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b0;
    tick(); cyc("wait_t1", 14'h02E0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc("wait_t1w1", 14'h0060, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc("wait_t1w2", 14'h0060, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); cyc("wait_t1w3", 14'h0060, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    tick(); cyc("wait_t2", 14'h0018, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("wait_t5 reg_in", reg_in, 16'h0010);
    tick(); chk("wait_done_c10", done, 1'b1);
    tick(); chk("wait_pcin_once", pcin_cnt, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("clr_pre alu_op", alu_op, 5'h05);
    #2 clear = 1'b0;
    #1 cyc("clr_async", 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);
    cyc_b("clr_async_b", 14'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    #1 clear = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    add_run("rerun");
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("hold_busy_c%0d", c), busy, (c % 8) != 0);
      chk($sformatf("hold_done_c%0d", c), done, (c % 8) == 7);
      chk($sformatf("hold_pcout_c%0d", c), PCout, (c % 8) == 1);
    end
    start = 1'b0;
    repeat (6) tick();
    chk("hold_end_idle", busy, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
